// File: rtl/usb_pd_char_fifo.sv
// rtl/usb_pd_char_fifo.sv - elastic char FIFO pacing decoded chars into uart_tx
// Circular buffer with one-char-per-frame read FSM and sticky drop accounting.
module usb_pd_char_fifo #(
   parameter int DEPTH       = 256,
   parameter int BSY_TIMEOUT = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       wr_valid_i,
   input  logic [7:0]                 wr_data_i,
   input  logic                       tx_bsy_i,
   output logic                       send_trig_o,
   output logic [7:0]                 send_data_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   output logic [15:0]                drop_cnt_o,
   input  logic                       ovf_clr_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (BSY_TIMEOUT > 1) ? $clog2(BSY_TIMEOUT) : 1;
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] TMO_LAST = CW'(BSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic [7:0]      send_data_q;
   logic            send_trig_q;
   logic            overflow_q, overflow_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic            full, empty, pop, push, drop;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   // A pop in the same cycle frees a slot, so a write at full is still accepted.
   assign push  = wr_valid_i && (!full || pop);
   assign drop  = wr_valid_i && full && !pop;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         send_trig_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         send_trig_q <= pop;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:    if (pop) state_d = SEND;
         SEND: begin
            cnt_d   = '0;
            state_d = WAIT_HI;
         end
         WAIT_HI: begin
            // A UART that never raises busy is assumed to have taken the char.
            if (tx_bsy_i || cnt_q == TMO_LAST) state_d = WAIT_LO;
            else                               cnt_d   = cnt_q + 1'b1;
         end
         WAIT_LO: if (!tx_bsy_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop         = (state_q == IDLE) && !empty && !tx_bsy_i;
      send_trig_o = send_trig_q;
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      if (drop) begin
         overflow_d = 1'b1;
         if (ovf_clr_i)                    drop_cnt_d = 16'd1;
         else if (drop_cnt_q != 16'hFFFF)  drop_cnt_d = drop_cnt_q + 16'd1;
      end else if (ovf_clr_i) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         send_data_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         if (pop) send_data_q <= mem[rd_ptr_q];
      end
   end

   // At full, read and write share an address; the read takes the old (oldest) char.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= wr_data_i;
   end

   assign send_data_o = send_data_q;
   assign level_o     = level_q;
   assign overflow_o  = overflow_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule
